// File: rtl/pimc_prio_if.sv
// Bus bundle for the interrupt message controller: raw interrupt lines,
// the notify/irqack message handshake and the MMIO register port.
interface pimc_prio_if #(
    parameter int IRQ_PIN_COUNT = 32
);
    logic [IRQ_PIN_COUNT-1:0] irq_in;
    logic                     irqack;
    logic [47:0]              mmio_addr;
    logic [31:0]              mmio_wdata;
    logic [31:0]              mmio_rdata;
    logic                     mmio_re;
    logic                     mmio_we;
    logic                     notify;
    logic [7:0]               lineno;
    logic [7:0]               processor_id;

    // SoC / CPU side: drives the lines, the ack and the MMIO requests
    modport master (
        output irq_in, irqack, mmio_addr, mmio_wdata, mmio_re, mmio_we,
        input  mmio_rdata, notify, lineno, processor_id
    );

    // Controller side
    modport slave (
        input  irq_in, irqack, mmio_addr, mmio_wdata, mmio_re, mmio_we,
        output mmio_rdata, notify, lineno, processor_id
    );
endinterface

// File: rtl/pimc_prio.sv
// Priority interrupt message controller: per-line routing entries, edge/level
// triggering, priority arbitration with lowest-index tie-break, in-service
// tracking with MMIO EOI, and a single-message notify/irqack handshake.
module pimc_prio #(
    parameter int          IRQ_PIN_COUNT   = 32,
    parameter int          PRIO_WIDTH      = 4,
    parameter logic [47:0] IRQTAB_MMIOBASE = 48'h1000000
) (
    input  logic       clk,
    input  logic       rst,
    pimc_prio_if.slave bus
);
    localparam int N  = IRQ_PIN_COUNT;
    localparam int PW = PRIO_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARB    = 2'd1,
        ST_NOTIFY = 2'd2
    } state_t;

    // Routing table
    logic [7:0]    cpu_r  [N];
    logic [PW-1:0] prio_r [N];
    logic [N-1:0]  mask_r;
    logic [N-1:0]  mode_r;

    // Line state
    logic [N-1:0]  irq_q_r;
    logic [N-1:0]  edge_pend_r;
    logic [N-1:0]  insvc_r;

    state_t        state_r;
    state_t        state_s;
    logic          notify_r;
    logic [7:0]    lineno_r;
    logic [7:0]    proc_id_r;
    logic [31:0]   rdata_r;

    logic [47:0]   off_s;
    logic [45:0]   word_s;
    logic          map_ok_s;
    logic          entry_hit_s;
    logic          eoi_hit_s;
    logic          status_hit_s;
    logic [IW-1:0] entry_idx_s;
    logic          eoi_we_s;

    logic [N-1:0]  pending_s;
    logic [N-1:0]  elig_s;
    logic [N-1:0]  edge_set_s;
    logic [N-1:0]  ack_vec_s;
    logic [N-1:0]  eoi_vec_s;
    logic          any_elig_s;
    logic [7:0]    win_s;
    logic [PW-1:0] best_s;
    logic          latch_s;
    logic          ack_s;
    logic [31:0]   rd_val_s;
    logic          unused_s;

    // Packs one routing entry into its register image; unused bits read 0
    function automatic logic [31:0] pack_entry(input logic [7:0] cpu, input logic msk,
                                               input logic md, input logic [PW-1:0] pr);
        logic [31:0] w;
        w          = 32'h0000_0000;
        w[7:0]     = cpu;
        w[8]       = msk;
        w[9]       = md;
        w[12 +: PW] = pr;
        return w;
    endfunction

    // MMIO address decode: word-aligned offsets inside the register window
    always_comb begin
        off_s        = bus.mmio_addr - IRQTAB_MMIOBASE;
        word_s       = off_s[47:2];
        map_ok_s     = (bus.mmio_addr >= IRQTAB_MMIOBASE) && (off_s[1:0] == 2'b00);
        entry_hit_s  = map_ok_s && (word_s < 46'(N));
        eoi_hit_s    = map_ok_s && (word_s == 46'(N));
        status_hit_s = map_ok_s && (word_s == 46'(N + 1));
        entry_idx_s  = word_s[IW-1:0];
        eoi_we_s     = bus.mmio_we && eoi_hit_s;
    end

    // Pending and eligibility: edge lines use the sticky flag, level lines follow irq_q
    always_comb begin
        pending_s  = (mode_r & edge_pend_r) | (~mode_r & irq_q_r);
        elig_s     = pending_s & ~mask_r & ~insvc_r;
        edge_set_s = bus.irq_in & ~irq_q_r & mode_r;
    end

    // Priority arbiter: scanning downward with >= lets the lowest index win ties
    always_comb begin
        any_elig_s = 1'b0;
        win_s      = 8'h00;
        best_s     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig_s[i] && (!any_elig_s || (prio_r[i] >= best_s))) begin
                any_elig_s = 1'b1;
                win_s      = 8'(i);
                best_s     = prio_r[i];
            end else begin
                best_s     = best_s;
            end
        end
    end

    // Per-line ack and EOI strobes; an EOI for a line not in service matches nothing
    always_comb begin
        ack_vec_s = '0;
        eoi_vec_s = '0;
        for (int i = 0; i < N; i++) begin
            ack_vec_s[i] = ack_s && (lineno_r == 8'(i));
            eoi_vec_s[i] = eoi_we_s && (bus.mmio_wdata[7:0] == 8'(i)) && insvc_r[i];
        end
    end

    // Handshake FSM next-state and control strobes
    always_comb begin
        state_s = state_r;
        latch_s = 1'b0;
        ack_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_elig_s) begin
                    state_s = ST_ARB;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (any_elig_s) begin
                    state_s = ST_NOTIFY;
                    latch_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_NOTIFY: begin
                if (bus.irqack) begin
                    state_s = ST_IDLE;
                    ack_s   = 1'b1;
                end else begin
                    state_s = ST_NOTIFY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Presented message: captured in ARB, held stable through NOTIFY
    always_ff @(posedge clk) begin
        if (rst) begin
            notify_r  <= 1'b0;
            lineno_r  <= 8'h00;
            proc_id_r <= 8'h00;
        end else begin
            notify_r <= (state_s == ST_NOTIFY);
            if (latch_s) begin
                lineno_r  <= win_s;
                proc_id_r <= cpu_r[win_s[IW-1:0]];
            end
        end
    end

    // Input stage, edge pending (new edge beats ack clear) and in-service (ack beats EOI)
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q_r     <= '0;
            edge_pend_r <= '0;
            insvc_r     <= '0;
        end else begin
            irq_q_r     <= bus.irq_in;
            edge_pend_r <= (edge_pend_r & ~ack_vec_s) | edge_set_s;
            insvc_r     <= (insvc_r & ~eoi_vec_s) | ack_vec_s;
        end
    end

    // Routing table writes; every entry comes out of reset masked
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cpu_r[i]  <= 8'h00;
                prio_r[i] <= '0;
            end
            mask_r <= '1;
            mode_r <= '0;
        end else if (bus.mmio_we && entry_hit_s) begin
            cpu_r[entry_idx_s]  <= bus.mmio_wdata[7:0];
            mask_r[entry_idx_s] <= bus.mmio_wdata[8];
            mode_r[entry_idx_s] <= bus.mmio_wdata[9];
            prio_r[entry_idx_s] <= bus.mmio_wdata[12 +: PW];
        end
    end

    // Read mux over the current (pre-write) register state
    always_comb begin
        rd_val_s = 32'h0000_0000;
        if (entry_hit_s) begin
            rd_val_s = pack_entry(cpu_r[entry_idx_s], mask_r[entry_idx_s],
                                  mode_r[entry_idx_s], prio_r[entry_idx_s]);
        end else if (status_hit_s) begin
            rd_val_s = {15'h0000, |pending_s, lineno_r, 7'h00, notify_r};
        end else begin
            rd_val_s = 32'h0000_0000;
        end
    end

    // Registered read data, held while no read is strobed
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (bus.mmio_re) begin
            rdata_r <= rd_val_s;
        end
    end

    assign unused_s         = ^{bus.mmio_wdata, off_s, word_s};
    assign bus.mmio_rdata   = rdata_r;
    assign bus.notify       = notify_r;
    assign bus.lineno       = lineno_r;
    assign bus.processor_id = proc_id_r;
endmodule
